alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched_if.sv | 56 +++++
 rtl/alu_sched.sv | 154 +++++++++++++++
 tb/tb_alu_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sched_if.sv
// alu_sched_if: bundles the two requester channels, the shared ALU drive/result
// lines and the response channel of alu_sched.
//   slave  : the scheduler itself
//   master : the environment (requesters A/B, the ALU, the response consumer)
interface alu_sched_if;
    // requester A
    logic       a_req;
    logic [1:0] a_op;
    logic [4:0] a_x;
    logic [4:0] a_y;
    logic       a_gnt;
    // requester B
    logic       b_req;
    logic [1:0] b_op;
    logic [4:0] b_x;
    logic [4:0] b_y;
    logic       b_gnt;
    // shared ALU drive
    logic [1:0] alu_s;
    logic [4:0] alu_x;
    logic [4:0] alu_y;
    // shared ALU results
    logic [4:0] alu_f;
    logic       alu_cout;
    logic       alu_ovf;
    // response channel
    logic       rsp_valid;
    logic       rsp_id;
    logic [4:0] rsp_f;
    logic       rsp_cout;
    logic       rsp_ovf;
    // status
    logic       busy;

    modport slave (
        input  a_req, a_op, a_x, a_y,
        output a_gnt,
        input  b_req, b_op, b_x, b_y,
        output b_gnt,
        output alu_s, alu_x, alu_y,
        input  alu_f, alu_cout, alu_ovf,
        output rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ovf,
        output busy
    );

    modport master (
        output a_req, a_op, a_x, a_y,
        input  a_gnt,
        output b_req, b_op, b_x, b_y,
        input  b_gnt,
        input  alu_s, alu_x, alu_y,
        output alu_f, alu_cout, alu_ovf,
        input  rsp_valid, rsp_id, rsp_f, rsp_cout, rsp_ovf,
        input  busy
    );
endinterface

// File: rtl/alu_sched.sv
// alu_sched: shares one external 5-bit ALU between two requesters (A, B).
// A granted request is registered onto the ALU inputs, held for EXEC_CYCLES
// cycles while the ALU settles, the result is captured, and a one-cycle
// response is issued. One operation in flight at a time.
//
// Optional feature: define ALU_SCHED_RR_EN for round-robin arbitration
// (pointer favours A after reset, moves to the loser after every transfer).
// Default build (macro undefined) uses fixed priority, A over B.
module alu_sched #(
    parameter int EXEC_CYCLES = 1       // ALU settle cycles per operation, 1..4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_sched_if.slave  bus
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       alu_s_q;
    logic [4:0]       alu_x_q;
    logic [4:0]       alu_y_q;

    logic             rsp_id_q;
    logic [4:0]       rsp_f_q;
    logic             rsp_cout_q;
    logic             rsp_ovf_q;

    logic             a_gnt_d;
    logic             b_gnt_d;
    logic             xfer_d;       // a transfer happens on the coming edge
    logic             cnt_done_d;   // last settle cycle of EXEC

`ifdef ALU_SCHED_RR_EN
    logic             ptr_q;        // 0: favour A, 1: favour B
`endif

    assign xfer_d     = a_gnt_d | b_gnt_d;
    assign cnt_done_d = (cnt_q == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (xfer_d)     state_d = ST_EXEC;
            ST_EXEC: if (cnt_done_d) state_d = ST_RESP;
            ST_RESP:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: grants only in IDLE and out of reset, winner picked by the arbiter
    always_comb begin
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
`ifdef ALU_SCHED_RR_EN
            if (bus.a_req && (!ptr_q || !bus.b_req)) begin
                a_gnt_d = 1'b1;
            end else if (bus.b_req) begin
                b_gnt_d = 1'b1;
            end
`else
            if (bus.a_req) begin
                a_gnt_d = 1'b1;
            end else if (bus.b_req) begin
                b_gnt_d = 1'b1;
            end
`endif
        end
    end

`ifdef ALU_SCHED_RR_EN
    // Round-robin pointer: after a transfer, favour the requester that did not win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (xfer_d) begin
            ptr_q <= a_gnt_d;
        end
    end
`endif

    // Settle counter: loaded on transfer, counts down while executing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (xfer_d) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == ST_EXEC) && !cnt_done_d) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // ALU drive registers: load the winner's operation, held stable until the next transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_s_q  <= '0;
            alu_x_q  <= '0;
            alu_y_q  <= '0;
            rsp_id_q <= 1'b0;
        end else if (xfer_d) begin
            alu_s_q  <= b_gnt_d ? bus.b_op : bus.a_op;
            alu_x_q  <= b_gnt_d ? bus.b_x  : bus.a_x;
            alu_y_q  <= b_gnt_d ? bus.b_y  : bus.a_y;
            rsp_id_q <= b_gnt_d;
        end
    end

    // Result capture at the end of the last settle cycle; flags pass through untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_f_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else if ((state_q == ST_EXEC) && cnt_done_d) begin
            rsp_f_q    <= bus.alu_f;
            rsp_cout_q <= bus.alu_cout;
            rsp_ovf_q  <= bus.alu_ovf;
        end
    end

    assign bus.a_gnt     = a_gnt_d;
    assign bus.b_gnt     = b_gnt_d;
    assign bus.alu_s     = alu_s_q;
    assign bus.alu_x     = alu_x_q;
    assign bus.alu_y     = alu_y_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_f     = rsp_f_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched. Two instances: EXEC_CYCLES=1 and
// EXEC_CYCLES=3. Each has a small behavioural ALU attached. Inputs change and
// outputs are sampled around the falling edge, away from the active edge.
// Arbitration expectations follow ALU_SCHED_RR_EN when it is defined.
module tb_alu_sched;

    logic clk = 1'b0;
    logic rst1_n;
    logic rst3_n;

    int n_checks = 0;
    int n_errors = 0;

    alu_sched_if if1();
    alu_sched_if if3();

    alu_sched #(.EXEC_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(if1));
    alu_sched #(.EXEC_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(if3));

    always #5 clk = ~clk;

    // Behavioural ALU: 00 add, 01 sub, 10 and, 11 xor; returns {ovf, cout, f}
    function automatic logic [6:0] alu_model(input logic [1:0] s, input logic [4:0] x,
                                             input logic [4:0] y);
        logic [5:0] r;
        logic       ovf;
        r   = '0;
        ovf = 1'b0;
        case (s)
            2'b00: begin
                r   = {1'b0, x} + {1'b0, y};
                ovf = (x[4] == y[4]) && (r[4] != x[4]);
            end
            2'b01: begin
                r   = {1'b0, x} + {1'b0, ~y} + 6'd1;
                ovf = (x[4] != y[4]) && (r[4] != x[4]);
            end
            2'b10: r = {1'b0, x & y};
            default: r = {1'b0, x ^ y};
        endcase
        return {ovf, r[5], r[4:0]};
    endfunction

    assign {if1.alu_ovf, if1.alu_cout, if1.alu_f} = alu_model(if1.alu_s, if1.alu_x, if1.alu_y);
    assign {if3.alu_ovf, if3.alu_cout, if3.alu_f} = alu_model(if3.alu_s, if3.alu_x, if3.alu_y);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic fall();
        @(negedge clk);
    endtask

    initial begin
        int seen;
        logic exp_b;

        rst1_n = 1'b0;
        rst3_n = 1'b0;
        {if1.a_req, if1.a_op, if1.a_x, if1.a_y} = '0;
        {if1.b_req, if1.b_op, if1.b_x, if1.b_y} = '0;
        {if3.a_req, if3.a_op, if3.a_x, if3.a_y} = '0;
        {if3.b_req, if3.b_op, if3.b_x, if3.b_y} = '0;
        if1.a_req = 1'b1;                     // grant must stay low under reset
        if3.b_req = 1'b1;
        fall(); fall(); #1;
        check("rst1_gnt",   {30'd0, if1.a_gnt, if1.b_gnt}, 32'd0);
        check("rst1_state", {30'd0, if1.busy, if1.rsp_valid}, 32'd0);
        check("rst1_alu",   {20'd0, if1.alu_s, if1.alu_x, if1.alu_y}, 32'd0);
        check("rst1_rsp",   {25'd0, if1.rsp_id, if1.rsp_f, if1.rsp_cout}, 32'd0);
        check("rst3_gnt",   {30'd0, if3.a_gnt, if3.b_gnt}, 32'd0);
        fall();
        if1.a_req = 1'b0;
        if3.b_req = 1'b0;
        rst1_n = 1'b1;
        rst3_n = 1'b1;

        // A: 6 + 7 = 13, one settle cycle
        fall();
        if1.a_req = 1'b1; if1.a_op = 2'b00; if1.a_x = 5'b00110; if1.a_y = 5'b00111;
        #1 check("t1_gnt", {30'd0, if1.a_gnt, if1.b_gnt}, 32'b10);
        check("t1_busy0", {31'd0, if1.busy}, 32'd0);
        fall();
        if1.a_req = 1'b0;
        #1 check("t1_alu", {20'd0, if1.alu_s, if1.alu_x, if1.alu_y}, {20'd0, 2'b00, 5'd6, 5'd7});
        check("t1_exec", {29'd0, if1.busy, if1.rsp_valid, if1.a_gnt}, 32'b100);
        fall(); #1;
        check("t1_rsp_valid", {31'd0, if1.rsp_valid}, 32'd1);
        check("t1_rsp", {24'd0, if1.rsp_id, if1.rsp_f, if1.rsp_cout, if1.rsp_ovf}, {24'd0, 1'b0, 5'd13, 1'b0, 1'b0});
        fall(); #1;
        check("t1_after", {30'd0, if1.busy, if1.rsp_valid}, 32'd0);
        check("t1_hold_f", {27'd0, if1.rsp_f}, 32'd13);

        // A: 14 + 7 = 21, signed overflow
        if1.a_req = 1'b1; if1.a_x = 5'b01110; if1.a_y = 5'b00111;
        #1 check("t2_gnt", {31'd0, if1.a_gnt}, 32'd1);
        fall();
        if1.a_req = 1'b0;
        fall(); #1;
        check("t2_rsp", {24'd0, if1.rsp_valid, if1.rsp_f, if1.rsp_cout, if1.rsp_ovf}, {24'd0, 1'b1, 5'd21, 1'b0, 1'b1});
        fall(); #1;
        check("t2_hold", {24'd0, if1.rsp_valid, if1.rsp_f, if1.rsp_cout, if1.rsp_ovf}, {24'd0, 1'b0, 5'd21, 1'b0, 1'b1});

        // B raised during RESP waits for the following IDLE cycle
        if1.a_req = 1'b1; if1.a_x = 5'd1; if1.a_y = 5'd2;
        fall();
        if1.a_req = 1'b0;
        fall();
        if1.b_req = 1'b1; if1.b_op = 2'b10; if1.b_x = 5'b11100; if1.b_y = 5'b10101;
        #1 check("t3_resp_nognt", {30'd0, if1.rsp_valid, if1.b_gnt}, 32'b10);
        fall(); #1;
        check("t3_idle_gnt", {30'd0, if1.busy, if1.b_gnt}, 32'b01);
        fall();
        if1.b_req = 1'b0;
        fall(); #1;
        check("t3_rsp", {25'd0, if1.rsp_valid, if1.rsp_id, if1.rsp_f}, {25'd0, 1'b1, 1'b1, 5'd20});

        // B request withdrawn while busy produces nothing; A: 3 - 5 = -2
        fall();
        if1.a_req = 1'b1; if1.a_op = 2'b01; if1.a_x = 5'd3; if1.a_y = 5'd5;
        #1 check("t4_gnt", {31'd0, if1.a_gnt}, 32'd1);
        fall();
        if1.a_req = 1'b0;
        if1.b_req = 1'b1;
        #1 check("t4_exec_nognt", {31'd0, if1.b_gnt}, 32'd0);
        fall(); #1;
        check("t4_rsp", {24'd0, if1.rsp_valid, if1.rsp_f, if1.rsp_cout, if1.rsp_ovf}, {24'd0, 1'b1, 5'b11110, 1'b0, 1'b0});
        if1.b_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            fall(); #1;
            if (if1.busy || if1.rsp_valid || if1.b_gnt) seen++;
        end
        check("t4_dropped_req", seen, 0);

        // Reset clears captured results at once
        fall();
        rst1_n = 1'b0;
        #1 check("t5_rst_rsp", {27'd0, if1.rsp_f}, 32'd0);
        check("t5_rst_alu", {20'd0, if1.alu_s, if1.alu_x, if1.alu_y}, 32'd0);

        // Both requesting continuously
        fall();
        rst1_n = 1'b1;
        if1.a_req = 1'b1; if1.a_op = 2'b00; if1.a_x = 5'd1;  if1.a_y = 5'd1;
        if1.b_req = 1'b1; if1.b_op = 2'b10; if1.b_x = 5'd31; if1.b_y = 5'd15;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_SCHED_RR_EN
            exp_b = k[0];
`else
            exp_b = 1'b0;
`endif
            #1 check($sformatf("t6_gnt%0d", k), {30'd0, if1.a_gnt, if1.b_gnt}, {30'd0, !exp_b, exp_b});
            fall();
            fall(); #1;
            check($sformatf("t6_rsp%0d", k), {25'd0, if1.rsp_valid, if1.rsp_id, if1.rsp_f},
                  {25'd0, 1'b1, exp_b, (exp_b ? 5'd15 : 5'd2)});
            fall();
        end
        if1.a_req = 1'b0;
        if1.b_req = 1'b0;

        // EXEC_CYCLES=3, B: 7 xor 1 = 6
        fall();
        if3.b_req = 1'b1; if3.b_op = 2'b11; if3.b_x = 5'b00111; if3.b_y = 5'b00001;
        #1 check("t7_gnt", {30'd0, if3.a_gnt, if3.b_gnt}, 32'b01);
        for (int i = 1; i <= 3; i++) begin
            fall();
            if (i == 1) if3.b_req = 1'b0;
            #1 check($sformatf("t7_exec%0d", i), {18'd0, if3.busy, if3.rsp_valid, if3.alu_s, if3.alu_x, if3.alu_y},
                     {18'd0, 1'b1, 1'b0, 2'b11, 5'd7, 5'd1});
        end
        fall(); #1;
        check("t7_rsp", {24'd0, if3.busy, if3.rsp_valid, if3.rsp_id, if3.rsp_f}, {24'd0, 1'b1, 1'b1, 1'b1, 5'd6});
        fall(); #1;
        check("t7_done", {30'd0, if3.busy, if3.rsp_valid}, 32'd0);

        // Reset pulse during EXEC aborts the operation
        if3.a_req = 1'b1; if3.a_op = 2'b00; if3.a_x = 5'd2; if3.a_y = 5'd3;
        #1 check("t8_gnt", {31'd0, if3.a_gnt}, 32'd1);
        fall();
        if3.a_req = 1'b0;
        #1 check("t8_busy", {31'd0, if3.busy}, 32'd1);
        rst3_n = 1'b0;
        #1 check("t8_rst_out", {12'd0, if3.busy, if3.rsp_valid, if3.rsp_id, if3.rsp_f, if3.rsp_cout, if3.rsp_ovf,
                                if3.alu_s, if3.alu_x, if3.alu_y}, 32'd0);
        fall();
        rst3_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            fall(); #1;
            if (if3.rsp_valid || if3.busy) seen++;
        end
        check("t8_no_rsp", seen, 0);
        if3.a_req = 1'b1; if3.a_x = 5'd4; if3.a_y = 5'd5;
        #1 check("t8_regnt", {31'd0, if3.a_gnt}, 32'd1);
        fall();
        if3.a_req = 1'b0;
        fall(); fall(); fall(); #1;
        check("t8_rsp", {25'd0, if3.rsp_valid, if3.rsp_id, if3.rsp_f}, {25'd0, 1'b1, 1'b0, 5'd9});
        fall();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
